// File: rtl/sync_fifo_pkg.sv
// Shared constants for the parameterised synchronous FIFO: config register
// addresses and STATUS register bit positions.
package sync_fifo_pkg;

  localparam logic [1:0] CFG_AF_THR = 2'd0;
  localparam logic [1:0] CFG_AE_THR = 2'd1;
  localparam logic [1:0] CFG_STATUS = 2'd2;

  localparam int STAT_OVF = 0;
  localparam int STAT_UDF = 1;

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module sync_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // storage write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with programmable almost-full/empty thresholds,
// sticky error status and config port. Define SYNC_FIFO_FWFT_EN for show-ahead reads.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_enb,
  input  logic              rd_enb,
  input  logic              cfg_wr,
  input  logic              cfg_rd,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int THR_W = AW + 1;

  logic [AW:0]       wr_ptr_r, rd_ptr_r;
  logic [AW:0]       af_thr_r, ae_thr_r;
  logic              ovf_sticky_r, udf_sticky_r;
  logic              push_req_s, pop_req_s, push_ok_s, pop_ok_s;
  logic              ovf_ev_s, udf_ev_s, sts_clr_ovf_s, sts_clr_udf_s;
  logic [DATA_W-1:0] cfg_rd_val_s;
  logic [DATA_W-1:0] ram_rdata_s;

  assign count        = wr_ptr_r - rd_ptr_r;
  assign empty        = (wr_ptr_r == rd_ptr_r);
  assign full         = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign almost_full  = (count >= af_thr_r);
  assign almost_empty = (count <= ae_thr_r);

  // request qualification; config access and flush mask data requests without error
  always_comb begin
    push_req_s    = wr_enb & ~cfg_wr & ~flush;
    pop_req_s     = rd_enb & ~cfg_rd & ~flush;
    pop_ok_s      = pop_req_s & ~empty;
    push_ok_s     = push_req_s & (~full | pop_ok_s);
    ovf_ev_s      = push_req_s & ~push_ok_s;
    udf_ev_s      = pop_req_s & ~pop_ok_s;
    sts_clr_ovf_s = 1'b0;
    sts_clr_udf_s = 1'b0;
    if (cfg_wr && (cfg_addr == CFG_STATUS)) begin
      sts_clr_ovf_s = data_in[STAT_OVF];
      sts_clr_udf_s = data_in[STAT_UDF];
    end else begin
      sts_clr_ovf_s = 1'b0;
      sts_clr_udf_s = 1'b0;
    end
  end

  // config read mux, zero-extended
  always_comb begin
    cfg_rd_val_s = '0;
    case (cfg_addr)
      CFG_AF_THR: cfg_rd_val_s[AW:0] = af_thr_r;
      CFG_AE_THR: cfg_rd_val_s[AW:0] = ae_thr_r;
      CFG_STATUS: begin
        cfg_rd_val_s[STAT_OVF] = ovf_sticky_r;
        cfg_rd_val_s[STAT_UDF] = udf_sticky_r;
      end
      default:    cfg_rd_val_s = '0;
    endcase
  end

  // pointers, thresholds, status and error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      af_thr_r     <= THR_W'(DEPTH - 2);
      ae_thr_r     <= THR_W'(2);
      ovf_sticky_r <= 1'b0;
      udf_sticky_r <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      cfg_rdata    <= '0;
    end else begin
      if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        wr_ptr_r <= wr_ptr_r + THR_W'(push_ok_s);
        rd_ptr_r <= rd_ptr_r + THR_W'(pop_ok_s);
      end
      if (cfg_wr && (cfg_addr == CFG_AF_THR)) af_thr_r <= data_in[AW:0];
      if (cfg_wr && (cfg_addr == CFG_AE_THR)) ae_thr_r <= data_in[AW:0];
      // a new event wins over a same-cycle clear
      ovf_sticky_r <= (ovf_sticky_r & ~sts_clr_ovf_s) | ovf_ev_s;
      udf_sticky_r <= (udf_sticky_r & ~sts_clr_udf_s) | udf_ev_s;
      overflow     <= ovf_ev_s;
      underflow    <= udf_ev_s;
      if (cfg_rd) cfg_rdata <= cfg_rd_val_s;
    end
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (ram_rdata_s)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // masking on empty keeps never-written entries off the output
  assign data_out   = empty ? '0 : ram_rdata_s;
  assign data_valid = ~empty;
`else
  logic [DATA_W-1:0] data_out_r;
  logic              data_valid_r;

  // registered read: popped word appears one cycle after acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
    end else begin
      data_valid_r <= pop_ok_s;
      if (pop_ok_s) data_out_r <= ram_rdata_s;
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0, flush = 1'b0, wr_enb = 1'b0, rd_enb = 1'b0;
  logic              cfg_wr = 1'b0, cfg_rd = 1'b0;
  logic [1:0]        cfg_addr = 2'd0;
  logic [DATA_W-1:0] data_in = 8'd0;
  logic [DATA_W-1:0] data_out, cfg_rdata;
  logic              data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]       count;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_enb(wr_enb), .rd_enb(rd_enb),
    .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_addr(cfg_addr), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .cfg_rdata(cfg_rdata), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [DATA_W-1:0] q[$];
  int                af_m, ae_m;
  logic              ovf_st_m, udf_st_m, ovf_m, udf_m, dv_m;
  logic [DATA_W-1:0] dout_m, rdata_m;
  int                vectors = 0;
  int                miscompares = 0;

  task automatic check(input string tag);
    assert (count === 5'(q.size())) else begin
      miscompares++; $error("FAIL %s count: got %0d want %0d", tag, count, q.size());
    end
    assert (full === 1'(q.size() == DEPTH)) else begin
      miscompares++; $error("FAIL %s full: got %b want %b", tag, full, q.size() == DEPTH);
    end
    assert (empty === 1'(q.size() == 0)) else begin
      miscompares++; $error("FAIL %s empty: got %b want %b", tag, empty, q.size() == 0);
    end
    assert (almost_full === 1'(q.size() >= af_m)) else begin
      miscompares++; $error("FAIL %s almost_full: got %b want %b", tag, almost_full, q.size() >= af_m);
    end
    assert (almost_empty === 1'(q.size() <= ae_m)) else begin
      miscompares++; $error("FAIL %s almost_empty: got %b want %b", tag, almost_empty, q.size() <= ae_m);
    end
    assert (overflow === ovf_m) else begin
      miscompares++; $error("FAIL %s overflow: got %b want %b", tag, overflow, ovf_m);
    end
    assert (underflow === udf_m) else begin
      miscompares++; $error("FAIL %s underflow: got %b want %b", tag, underflow, udf_m);
    end
    assert (data_valid === dv_m) else begin
      miscompares++; $error("FAIL %s data_valid: got %b want %b", tag, data_valid, dv_m);
    end
    assert (data_out === dout_m) else begin
      miscompares++; $error("FAIL %s data_out: got %h want %h", tag, data_out, dout_m);
    end
    assert (cfg_rdata === rdata_m) else begin
      miscompares++; $error("FAIL %s cfg_rdata: got %h want %h", tag, cfg_rdata, rdata_m);
    end
  endtask

  // apply one cycle of inputs, advance the model, compare all outputs
  task automatic step(input string tag, input logic r, input logic w, input logic rd,
                      input logic cw, input logic cr, input logic [1:0] a,
                      input logic [7:0] d, input logic f);
    logic push_req, pop_req, pop_ok, push_ok;
    logic [DATA_W-1:0] rv;
    rst_n = r; wr_enb = w; rd_enb = rd; cfg_wr = cw; cfg_rd = cr;
    cfg_addr = a; data_in = d; flush = f;
    @(posedge clk);
    vectors++;
    if (!r) begin
      q.delete();
      af_m = DEPTH - 2; ae_m = 2;
      ovf_st_m = 1'b0; udf_st_m = 1'b0; ovf_m = 1'b0; udf_m = 1'b0;
      dv_m = 1'b0; dout_m = 8'h00; rdata_m = 8'h00;
    end else begin
      push_req = w & ~cw & ~f;
      pop_req  = rd & ~cr & ~f;
      pop_ok   = pop_req && (q.size() > 0);
      push_ok  = push_req && ((q.size() < DEPTH) || pop_ok);
      case (a)
        2'd0:    rv = 8'(af_m);
        2'd1:    rv = 8'(ae_m);
        2'd2:    rv = {6'd0, udf_st_m, ovf_st_m};
        default: rv = 8'h00;
      endcase
      if (cr) rdata_m = rv;
      ovf_m = push_req & ~push_ok;
      udf_m = pop_req & ~pop_ok;
      dv_m  = pop_ok;
      if (pop_ok) dout_m = q.pop_front();
      if (push_ok) q.push_back(d);
      if (cw && a == 2'd0) af_m = int'(d[AW:0]);
      if (cw && a == 2'd1) ae_m = int'(d[AW:0]);
      ovf_st_m = (ovf_st_m & ~(cw && a == 2'd2 && d[0])) | ovf_m;
      udf_st_m = (udf_st_m & ~(cw && a == 2'd2 && d[1])) | udf_m;
      if (f) q.delete();
    end
`ifdef SYNC_FIFO_FWFT_EN
    dv_m   = (q.size() > 0);
    dout_m = (q.size() > 0) ? q[0] : 8'h00;
`endif
    #1;
    check(tag);
  endtask

  initial begin
    // reset
    step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    step("reset", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    step("idle",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    // fill with 0x01..0x10
    for (int i = 1; i <= 16; i++)
      step("fill", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'(i), 1'b0);
    // overflow, sticky status read, W1C
    step("ovf_push",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'hAA, 1'b0);
    step("sts_rd",     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h00, 1'b0);
    step("sts_clr",    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h01, 1'b0);
    step("sts_rd2",    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h00, 1'b0);
    // full push+pop: count stays, no overflow
    step("full_pp",    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h11, 1'b0);
    // masked requests are not errors
    step("cfg_mask",   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 8'hFF, 1'b0);
    // drain
    for (int i = 0; i < 16; i++)
      step("drain", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    // empty push+pop: underflow, count 1
    step("empty_pp",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h5A, 1'b0);
    step("pop1",       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    // thresholds 5 / 3
    step("af_wr",      1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h05, 1'b0);
    step("ae_wr",      1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8'h03, 1'b0);
    step("af_rd",      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
    step("ae_rd",      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00, 1'b0);
    step("a3_rd",      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++)
      step("thr_fill", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'(8'h30 + i), 1'b0);
    step("flush",      1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    // wrap: 3 rounds of push 12 / pop 12
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++)
        step("wrap_push", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'(r * 16 + i + 64), 1'b0);
      for (int i = 0; i < 12; i++)
        step("wrap_pop", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    end
    // flush at count 7 keeps thresholds
    for (int i = 0; i < 7; i++)
      step("pre_flush", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'(8'hC0 + i), 1'b0);
    step("flush7",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    step("af_rd_kept", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
    // reset at count 9 with a pending pop
    for (int i = 0; i < 9; i++)
      step("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'(8'hE0 + i), 1'b0);
    step("pend_pop",   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
    step("mid_rst",    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
    step("post_rst",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h77, 1'b0);
    // random traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 600; i++) begin
      int wp;
      logic r, w, rd, cw, cr, f;
      wp = ((i / 50) % 2 == 0) ? 75 : 25;
      r  = ($urandom_range(0, 199) != 0);
      w  = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < 100 - wp);
      cw = ($urandom_range(0, 15) == 0);
      cr = ($urandom_range(0, 7) == 0);
      f  = ($urandom_range(0, 63) == 0);
      step("rand", r, w, rd, cw, cr, 2'($urandom_range(0, 3)), 8'($urandom), f);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
